// File: rtl/csa_acc_seq.sv
// Carry-save accumulator sequencer: sums a counted stream of W-bit operands in
// redundant (S, C) form, then resolves once and hands the result out on valid/ready.
module csa_acc_seq #(
  parameter int W     = 80,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             op_valid,
  input  logic [W-1:0]     op_data,
  output logic             op_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [W-1:0]     res_data,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     s_q, s_d;
  logic [W-1:0]     c_q, c_d;
  logic [W-1:0]     r_q, r_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] d);
    return a ^ b ^ d;
  endfunction

  // Majority shifted up one place; the top carry falls off (result is mod 2^W).
  function automatic logic [W-1:0] csa_carry(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] d);
    logic [W-1:0] maj;
    maj = (a & b) | (a & d) | (b & d);
    return {maj[W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    r_d     = r_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = '0;
          c_d     = '0;
          rem_d   = num_ops;
          state_d = (num_ops != '0) ? ACCUM : RESOLVE;
        end
      end
      ACCUM: begin
        if (op_valid) begin
          s_d   = csa_sum(s_q, c_q, op_data);
          c_d   = csa_carry(s_q, c_q, op_data);
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        r_d     = s_q + c_q;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign op_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = r_q;

endmodule

// File: tb/tb_csa_acc_seq.sv
// Bench for csa_acc_seq: directed jobs with literal results plus a cycle-level
// arithmetic reference model compared on every falling edge.
module tb_csa_acc_seq;

  localparam int W     = 80;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             op_valid;
  logic [W-1:0]     op_data;
  logic             op_ready;
  logic             busy;
  logic             res_valid;
  logic [W-1:0]     res_data;
  logic             res_ready;

  csa_acc_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_ops  (num_ops),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_ready (op_ready),
    .busy     (busy),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;
  int hs_cnt = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular addition of every accepted operand.
  // mode 0 idle, 1 taking operands, 2 resolving, 3 result held.
  int           m_mode = 0;
  int           m_left = 0;
  logic [W-1:0] m_sum  = '0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_sum = '0; m_res = '0;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_sum  = '0;
             m_left = int'(num_ops);
             m_mode = (num_ops != 0) ? 1 : 2;
           end
        1: if (op_valid) begin
             m_sum  = m_sum + op_data;
             m_left = m_left - 1;
             if (m_left == 0) m_mode = 2;
           end
        2: begin m_res = m_sum; m_mode = 3; end
        default: if (res_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("op_ready", op_ready, m_mode == 1);
      chk1("busy", busy, m_mode != 0);
      chk1("res_valid", res_valid, m_mode == 3);
      chkw("res_data", res_data, m_res);
    end
    if (op_valid && op_ready) hs_cnt++;
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_ops = CNT_W'(n); hs_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] d, input int gap);
    int t;
    op_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    op_valid = 1'b1; op_data = d;
    t = 0;
    @(negedge clk);
    while (!op_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chki("feed_timeout", t, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic get_result(input bit rand_rdy, output logic [W-1:0] res);
    bit got;
    int t;
    got = 1'b0; t = 0; res = 'x;
    while (!got && t < 2000) begin
      @(negedge clk);
      if (res_valid && res_ready) begin res = res_data; got = 1'b1; end
      @(posedge clk); #1;
      res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    if (!got) chki("result_timeout", t, 0);
    res_ready = 1'b1;
  endtask

  initial begin
    logic [W-1:0] res, drv_sum, d;
    logic [95:0]  r96;
    int           lat, n;
    bit           saw_ready;

    rst = 1'b1; start = 1'b0; num_ops = '0; op_valid = 1'b0; op_data = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_op_ready", op_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chkw("rst_res_data", res_data, '0);
    chk_en = 1'b1;

    // Basic sum with latency measurement
    @(posedge clk); #1 start = 1'b1; num_ops = 8'd3; hs_cnt = 0;
    @(posedge clk); #1 start = 1'b0; op_valid = 1'b1; op_data = 80'd5;
    @(posedge clk); #1 op_data = 80'd7;
    @(posedge clk); #1 op_data = 80'd9;
    @(posedge clk); #1 op_valid = 1'b0;
    lat = -1;
    for (int k = 4; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    chki("basic_latency", lat, 5);
    chkw("basic_sum", res_data, 80'd21);
    chki("basic_hs", hs_cnt, 3);
    @(negedge clk);
    chk1("basic_busy_after", busy, 1'b0);

    // Stalled operands wrapping to zero
    do_start(4);
    feed({W{1'b1}}, 2); feed({W{1'b1}}, 2); feed({W{1'b1}}, 2); feed(80'h3, 2);
    get_result(1'b0, res);
    chkw("stall_sum", res, 80'h0);
    chki("stall_hs", hs_cnt, 4);

    // Zero-length job
    saw_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1; num_ops = 8'd0; hs_cnt = 0;
    @(negedge clk); saw_ready |= op_ready;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      saw_ready |= op_ready;
      if (res_valid) begin lat = k; break; end
    end
    chki("zero_latency", lat, 2);
    chkw("zero_sum", res_data, 80'h0);
    chk1("zero_no_ready", saw_ready, 1'b0);
    @(posedge clk); #1;

    // Backpressure with ignored start pulses
    res_ready = 1'b0;
    do_start(2);
    feed(80'h1234, 0); feed(80'h1, 0);
    lat = 0;
    @(negedge clk);
    while (!res_valid && lat < 20) begin @(negedge clk); lat++; end
    for (int k = 0; k < 6; k++) begin
      chk1("bp_valid_hold", res_valid, 1'b1);
      chkw("bp_data_hold", res_data, 80'h1235);
      @(posedge clk); #1 start = k[0]; num_ops = 8'd7;
      @(negedge clk);
    end
    @(posedge clk); #1 start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk1("bp_still_valid", res_valid, 1'b1);
    @(negedge clk);
    chk1("bp_idle_busy", busy, 1'b0);
    chk1("bp_idle_valid", res_valid, 1'b0);

    // Reset mid-job, then a clean job
    do_start(5);
    feed(80'h77, 0); feed(80'h99, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", op_ready, 1'b0);
    chk1("mid_rst_valid", res_valid, 1'b0);
    do_start(1);
    feed(80'hA, 0);
    get_result(1'b0, res);
    chkw("after_rst_sum", res, 80'hA);

    // Randomised jobs
    for (int j = 0; j < 200; j++) begin
      n = $urandom_range(1, 255);
      drv_sum = '0;
      do_start(n);
      for (int i = 0; i < n; i++) begin
        r96 = {$urandom(), $urandom(), $urandom()};
        d = r96[W-1:0];
        drv_sum = drv_sum + d;
        feed(d, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      get_result(1'b1, res);
      chkw("rand_sum", res, drv_sum);
      chki("rand_hs", hs_cnt, n);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csa_acc_seq.md
# csa_acc_seq

Sequencer that drives an 80-bit 3:2 carry-save adder stage to sum a stream of operands, e.g. partial-product rows from the 40x40 multiplier array. Running state is held in redundant (sum, carry) form, so each accepted operand costs one CSA pass with no carry propagation. After the programmed operand count is reached, the block does one carry-propagate resolve and presents the result through a valid/ready handshake. It sits between the partial-product generator and the modular-reduction stage.

## Interface
- W, 80: datapath width in bits; the CSA stage is W bits wide.
- CNT_W, 8: width of the operand-count field; max operands per job = 2^CNT_W - 1.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- num_ops  input  CNT_W  operands in the job; sampled when start is accepted.
- op_valid  input  1  operand present on op_data.
- op_data  input  W  operand.
- op_ready  output  1  block accepts an operand this cycle.
- busy  output  1  high in every state except IDLE.
- res_valid  output  1  result valid.
- res_data  output  W  resolved sum, mod 2^W.
- res_ready  input  1  consumer accepts the result.

## Operation
- Internal registers:
  - S, C: W bits each, the carry-save pair.
  - remaining: CNT_W bits.
  - R: W-bit result register driving res_data.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: op_ready=0, res_valid=0. On start=1:
  - S and C clear to 0; remaining loads num_ops.
  - Next state is ACCUM if num_ops != 0, otherwise RESOLVE.
- ACCUM: op_ready=1. On each handshake (op_valid & op_ready):
  - S <= S ^ C ^ op_data.
  - C <= {maj(S,C,op_data)[W-2:0], 1'b0}. Bit 0 is forced to 0; the majority bit at position W-1 is discarded (arithmetic mod 2^W).
  - remaining decrements. When remaining==1 at the handshake, the next state is RESOLVE.
  - With no handshake, all registers hold.
- RESOLVE: op_ready=0. R <= (S + C) mod 2^W, a single W-bit carry-propagate add. Next state is DONE.
- DONE: res_valid=1 and res_data=R, both held stable until res_ready=1. On res_ready, next state is IDLE.
- start is ignored outside IDLE. op_valid is ignored outside ACCUM; no operand is consumed.
- Invariant: in ACCUM, (S + C) mod 2^W equals the sum so far of accepted operands, mod 2^W.
- rst in any state, including mid-job:
  - State goes to IDLE; S, C, R and remaining clear to 0.
  - Any partial job is discarded and no result is produced.

## Timing
- Values after reset: op_ready=0, busy=0, res_valid=0, res_data=0.
- Cycle numbering: start accepted at cycle t.
  - ACCUM begins at t+1.
  - With op_valid held high, operands are accepted at t+1 .. t+N.
  - RESOLVE occurs at t+N+1.
  - res_valid rises at t+N+2.
  - Total latency: N+2 cycles from start to res_valid.
- num_ops=0: RESOLVE at t+1, res_valid at t+2, res_data=0.
- Throughput: 1 operand per cycle while in ACCUM. op_valid gaps stall accumulation only.
- Result handshake:
  - If res_ready=1 in the first DONE cycle, res_valid lasts exactly one cycle.
  - A new start may be accepted on the cycle after DONE exits (the IDLE cycle).
  - Minimum job-to-job spacing is N+3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to op_ready, busy or res_valid.

## Test plan
- Basic sum: reset, then start with num_ops=3 and operands 5, 7, 9 back-to-back, res_ready=1.
  - Required: res_valid exactly 5 cycles after the start cycle.
  - Required: res_data=21; busy low the cycle after.
- Stalls: num_ops=4 with operands 0xFFFF_FFFF_FFFF_FFFF_FFFF (all-ones, 80 bit) ×3 and 0x3.
  - op_valid deasserted for 2 cycles between each operand.
  - Required: res_data=0x0 (3·(2^80−1)+3 ≡ 0 mod 2^80).
  - Required: op_ready high throughout ACCUM; nothing is consumed while op_valid=0.
- Zero-length job: start with num_ops=0.
  - Required: res_valid at t+2 with res_data=0; op_ready never asserted.
- Backpressure: num_ops=2 with operands 0x1234 and 0x1; res_ready held low for 6 cycles.
  - Required: res_valid and res_data=0x1235 stay stable for the whole hold.
  - Required: start pulses during the hold are ignored.
  - Required: IDLE is reached one cycle after res_ready rises.
- Reset mid-job: num_ops=5; assert rst after 2 operands.
  - Required: next cycle busy=0, op_ready=0, res_valid=0.
  - A new job, num_ops=1 with operand 0xA, must then return 0xA (no residue from the aborted job).
- Randomized equivalence: 200 jobs, num_ops from 1 to 255, random W-bit operands, random op_valid/res_ready gaps.
  - Required: res_data equals the reference sum mod 2^80.
  - Required: exactly num_ops handshakes per job.
